mc_cache_dma_slot_xbar: RTL and testbench
=========================================

Name: mc_cache_dma_slot_xbar

Overview:
- Routes the DMA interfaces of num_cache_p vcaches onto num_slot_p downstream DMA slots, one transaction per slot at a time.
- Each slot feeds one single-cache cache-to-AXI converter, so one memory system can use 1..N AXI ports.
- Generalises the fixed "all caches into one converter" and "one converter per cache" arrangements.
- Adds per-slot round-robin arbitration and a selectable slot-mapping mode.

Parameters:
- num_cache_p, 8, number of cache DMA channels.
- num_slot_p, 2, number of downstream slots; power of 2; 1 <= num_slot_p <= num_cache_p.
- addr_width_p, 28, DMA byte-address width.
- data_width_p, 32, DMA data beat width.
- block_size_in_words_p, 8, beats per DMA transaction; power of 2, >= 2.
- sel_mode_p, 0, slot mapping: 0 = cache index mod num_slot_p; 1 = address interleave.
- Local pkt_width_lp = addr_width_p+1. Packet = {write_not_read (MSB), addr}.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- dma_pkt_i  in  num_cache_p x pkt_width_lp  cache request packets.
- dma_pkt_v_i  in  num_cache_p  packet valid.
- dma_pkt_yumi_o  out  num_cache_p  packet consumed.
- dma_data_o  out  num_cache_p x data_width_p  fill data to caches.
- dma_data_v_o  out  num_cache_p  fill valid.
- dma_data_ready_i  in  num_cache_p  cache ready for fill.
- dma_data_i  in  num_cache_p x data_width_p  evict data from caches.
- dma_data_v_i  in  num_cache_p  evict valid.
- dma_data_yumi_o  out  num_cache_p  evict consumed.
- slot_dma_pkt_o  out  num_slot_p x pkt_width_lp  packet to slot.
- slot_dma_pkt_v_o  out  num_slot_p  packet valid.
- slot_dma_pkt_yumi_i  in  num_slot_p  slot consumed packet.
- slot_dma_data_i  in  num_slot_p x data_width_p  fill data from slot.
- slot_dma_data_v_i  in  num_slot_p  fill valid.
- slot_dma_data_ready_o  out  num_slot_p  ready for fill.
- slot_dma_data_o  out  num_slot_p x data_width_p  evict data to slot.
- slot_dma_data_v_o  out  num_slot_p  evict valid.
- slot_dma_data_yumi_i  in  num_slot_p  slot consumed evict beat.

Behaviour:
- **Target slot, mode 0:** target(c) = c mod num_slot_p.
- **Target slot, mode 1:** target = addr[off +: lg(num_slot_p)], where off = lg(block_size_in_words_p*data_width_p/8). With num_slot_p=1 the target is always 0.
- **Address pass-through:** packets are forwarded unmodified.
- **Per-slot FSM states:** IDLE, READ, WRITE. Per-slot state held: owner index, beat counter of width lg(block_size_in_words_p), and round-robin pointer.
- **Per-cache busy bit:** set while the cache owns any slot.
- **Eligibility:** cache c is eligible for slot s iff dma_pkt_v_i[c], target==s, !busy[c], and slot s is IDLE.
- **IDLE:**
  - Round-robin pick among eligible caches, starting at rr_ptr.
  - Drive slot_dma_pkt_o/v_o combinationally from the winner.
  - On slot_dma_pkt_yumi_i: raise dma_pkt_yumi_o[winner] the same cycle, latch owner, set busy, clear counter, set rr_ptr = winner+1 (wrapping at num_cache_p).
  - Next state is WRITE if the packet MSB is 1, else READ.
  - rr_ptr does not move without yumi, so the winner stays stable while the slot stalls.
- **READ:**
  - dma_data_o[owner] = slot_dma_data_i; dma_data_v_o[owner] = slot_dma_data_v_i.
  - slot_dma_data_ready_o = dma_data_ready_i[owner].
  - A beat fires on v&ready and increments the counter.
  - The beat with counter == block_size_in_words_p-1 returns the slot to IDLE and clears busy[owner].
- **WRITE:**
  - slot_dma_data_o = dma_data_i[owner]; slot_dma_data_v_o = dma_data_v_i[owner].
  - dma_data_yumi_o[owner] = slot_dma_data_yumi_i.
  - Counting and the last-beat rule are the same as READ.
- **Non-owners:** data outputs 0, valids 0, yumis 0, readies 0. slot_dma_data_ready_o is 0 outside READ.
- **Latency:**
  - Packet path: 0 cycles, combinational.
  - After the last beat, the next packet on that slot can be accepted one cycle later, because IDLE is registered.
- **Concurrency:** two slots may run simultaneously for different caches. A cache is never granted by two slots, because of busy.
- **Simultaneous requests:** when several caches request the same slot in the same cycle, exactly one yumi is raised per slot per cycle.
- **Reset:** all FSMs IDLE, busy=0, rr_ptr=0, counters=0, all outputs 0 during reset. Reset mid-transaction abandons the transfer with no flush.
- **Assertions (non-synth):**
  - num_slot_p is a power of 2 and <= num_cache_p.
  - No slot_dma_data_v_i outside READ.
  - No slot yumi without v.

Test Plan:
- num_cache_p=4, num_slot_p=1, mode 0; cache 2 issues a read at 0x100 -> slot 0 gets pkt 0x100 in the same cycle; 8 fill beats 0xA0..0xA7 arrive at cache 2 in order; slot returns to IDLE after beat 8.
- Caches 0,1,2,3 issue a write at the same cycle to one slot -> grants in order 0,1,2,3; each passes 8 evict beats; no interleaving; 1-cycle gap between transfers.
- num_slot_p=2, mode 0; caches 0 and 1 read together -> slots 0 and 1 work in parallel; both finish in the same cycle under back-to-back ready.
- mode 1, 32B blocks; addresses 0x00 and 0x20 -> slot 0 and slot 1 respectively; address 0x40 -> slot 0.
- Cache drops dma_data_ready_i for 3 cycles mid-fill -> slot_dma_data_ready_o is low for those 3 cycles; beat count still totals 8; no beats lost.
- reset_i asserted at beat 4 of a write -> all valids/yumis 0 the next cycle; a new read is accepted immediately after reset deasserts.

Source files
------------

// File: rtl/mc_cache_dma_slot_xbar_if.sv
// Cache-side and slot-side DMA signal bundle for mc_cache_dma_slot_xbar.
// The crossbar takes the slave modport; the caches/slots environment takes master.
interface mc_cache_dma_slot_xbar_if #(
  parameter int num_cache_p  = 8,
  parameter int num_slot_p   = 2,
  parameter int addr_width_p = 28,
  parameter int data_width_p = 32
);
  localparam int pkt_width_lp = addr_width_p + 1;

  logic [num_cache_p-1:0][pkt_width_lp-1:0] dma_pkt_i;
  logic [num_cache_p-1:0]                   dma_pkt_v_i;
  logic [num_cache_p-1:0]                   dma_pkt_yumi_o;
  logic [num_cache_p-1:0][data_width_p-1:0] dma_data_o;
  logic [num_cache_p-1:0]                   dma_data_v_o;
  logic [num_cache_p-1:0]                   dma_data_ready_i;
  logic [num_cache_p-1:0][data_width_p-1:0] dma_data_i;
  logic [num_cache_p-1:0]                   dma_data_v_i;
  logic [num_cache_p-1:0]                   dma_data_yumi_o;

  logic [num_slot_p-1:0][pkt_width_lp-1:0]  slot_dma_pkt_o;
  logic [num_slot_p-1:0]                    slot_dma_pkt_v_o;
  logic [num_slot_p-1:0]                    slot_dma_pkt_yumi_i;
  logic [num_slot_p-1:0][data_width_p-1:0]  slot_dma_data_i;
  logic [num_slot_p-1:0]                    slot_dma_data_v_i;
  logic [num_slot_p-1:0]                    slot_dma_data_ready_o;
  logic [num_slot_p-1:0][data_width_p-1:0]  slot_dma_data_o;
  logic [num_slot_p-1:0]                    slot_dma_data_v_o;
  logic [num_slot_p-1:0]                    slot_dma_data_yumi_i;

  modport slave (
    input  dma_pkt_i, dma_pkt_v_i, dma_data_ready_i, dma_data_i, dma_data_v_i,
           slot_dma_pkt_yumi_i, slot_dma_data_i, slot_dma_data_v_i, slot_dma_data_yumi_i,
    output dma_pkt_yumi_o, dma_data_o, dma_data_v_o, dma_data_yumi_o,
           slot_dma_pkt_o, slot_dma_pkt_v_o, slot_dma_data_ready_o, slot_dma_data_o,
           slot_dma_data_v_o
  );

  modport master (
    output dma_pkt_i, dma_pkt_v_i, dma_data_ready_i, dma_data_i, dma_data_v_i,
           slot_dma_pkt_yumi_i, slot_dma_data_i, slot_dma_data_v_i, slot_dma_data_yumi_i,
    input  dma_pkt_yumi_o, dma_data_o, dma_data_v_o, dma_data_yumi_o,
           slot_dma_pkt_o, slot_dma_pkt_v_o, slot_dma_data_ready_o, slot_dma_data_o,
           slot_dma_data_v_o
  );
endinterface

// File: rtl/mc_cache_dma_slot_xbar.sv
// Routes num_cache_p vcache DMA channels onto num_slot_p downstream DMA slots,
// one block transaction per slot, with per-slot round-robin arbitration.
module mc_cache_dma_slot_xbar #(
  parameter int num_cache_p           = 8,
  parameter int num_slot_p            = 2,
  parameter int addr_width_p          = 28,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int sel_mode_p            = 0
) (
  input logic clk_i,
  input logic reset_i,
  mc_cache_dma_slot_xbar_if.slave bus
);
  localparam int pkt_width_lp = addr_width_p + 1;
  localparam int lg_slot_lp   = (num_slot_p > 1) ? $clog2(num_slot_p) : 1;
  localparam int lg_cache_lp  = (num_cache_p > 1) ? $clog2(num_cache_p) : 1;
  localparam int cnt_width_lp = $clog2(block_size_in_words_p);
  localparam int off_lp       = $clog2(block_size_in_words_p * data_width_p / 8);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e                  state_r  [num_slot_p];
  logic [lg_cache_lp-1:0]  owner_r  [num_slot_p];
  logic [cnt_width_lp-1:0] cnt_r    [num_slot_p];
  logic [lg_cache_lp-1:0]  rr_ptr_r [num_slot_p];
  logic [num_cache_p-1:0]  busy_r;

  logic [lg_slot_lp-1:0]   target    [num_cache_p];
  logic                    grant_v   [num_slot_p];
  logic [lg_cache_lp-1:0]  grant_idx [num_slot_p];
  logic                    beat      [num_slot_p];
  logic [lg_cache_lp-1:0]  cand;

  for (genvar c = 0; c < num_cache_p; c++) begin : g_target
    if (num_slot_p == 1) begin : g_one
      assign target[c] = '0;
    end else if (sel_mode_p == 0) begin : g_mod
      assign target[c] = lg_slot_lp'(c % num_slot_p);
    end else begin : g_addr
      assign target[c] = bus.dma_pkt_i[c][off_lp +: lg_slot_lp];
    end
  end

  function automatic int rr_idx(input int base, input int i);
    return (base + i) % num_cache_p;
  endfunction

  always_comb begin
    // NOTE: every output and temporary gets a default first so no path infers a latch.
    bus.dma_pkt_yumi_o        = '0;
    bus.dma_data_o            = '0;
    bus.dma_data_v_o          = '0;
    bus.dma_data_yumi_o       = '0;
    bus.slot_dma_pkt_o        = '0;
    bus.slot_dma_pkt_v_o      = '0;
    bus.slot_dma_data_ready_o = '0;
    bus.slot_dma_data_o       = '0;
    bus.slot_dma_data_v_o     = '0;
    cand                      = '0;
    for (int s = 0; s < num_slot_p; s++) begin
      grant_v[s]   = 1'b0;
      grant_idx[s] = '0;
      beat[s]      = 1'b0;
      if (!reset_i) begin
        unique case (state_r[s])
          IDLE: begin
            // First eligible cache scanning upward from rr_ptr wins.
            for (int i = 0; i < num_cache_p; i++) begin
              cand = lg_cache_lp'(rr_idx(int'(rr_ptr_r[s]), i));
              if (!grant_v[s] && bus.dma_pkt_v_i[cand] && !busy_r[cand]
                  && int'(target[cand]) == s) begin
                grant_v[s]   = 1'b1;
                grant_idx[s] = cand;
              end
            end
            if (grant_v[s]) begin
              bus.slot_dma_pkt_o[s]            = bus.dma_pkt_i[grant_idx[s]];
              bus.slot_dma_pkt_v_o[s]          = 1'b1;
              bus.dma_pkt_yumi_o[grant_idx[s]] = bus.slot_dma_pkt_yumi_i[s];
            end
          end
          READ: begin
            bus.dma_data_o[owner_r[s]]   = bus.slot_dma_data_i[s];
            bus.dma_data_v_o[owner_r[s]] = bus.slot_dma_data_v_i[s];
            bus.slot_dma_data_ready_o[s] = bus.dma_data_ready_i[owner_r[s]];
            beat[s] = bus.slot_dma_data_v_i[s] & bus.dma_data_ready_i[owner_r[s]];
          end
          WRITE: begin
            bus.slot_dma_data_o[s]          = bus.dma_data_i[owner_r[s]];
            bus.slot_dma_data_v_o[s]        = bus.dma_data_v_i[owner_r[s]];
            bus.dma_data_yumi_o[owner_r[s]] = bus.slot_dma_data_yumi_i[s];
            beat[s] = bus.slot_dma_data_yumi_i[s] & bus.dma_data_v_i[owner_r[s]];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: these are a handful of control flops, not a memory, so all are reset.
      for (int s = 0; s < num_slot_p; s++) begin
        state_r[s]  <= IDLE;
        owner_r[s]  <= '0;
        cnt_r[s]    <= '0;
        rr_ptr_r[s] <= '0;
      end
      busy_r <= '0;
    end else begin
      // NOTE: non-blocking so every slot sees the same pre-edge busy/owner values.
      for (int s = 0; s < num_slot_p; s++) begin
        unique case (state_r[s])
          IDLE: if (grant_v[s] && bus.slot_dma_pkt_yumi_i[s]) begin
            owner_r[s]             <= grant_idx[s];
            cnt_r[s]               <= '0;
            busy_r[grant_idx[s]]   <= 1'b1;
            rr_ptr_r[s]            <= (int'(grant_idx[s]) == num_cache_p - 1)
                                      ? '0 : grant_idx[s] + 1'b1;
            state_r[s]             <= bus.dma_pkt_i[grant_idx[s]][pkt_width_lp-1]
                                      ? WRITE : READ;
          end
          READ, WRITE: if (beat[s]) begin
            cnt_r[s] <= cnt_r[s] + 1'b1;
            if (cnt_r[s] == cnt_width_lp'(block_size_in_words_p - 1)) begin
              state_r[s]         <= IDLE;
              busy_r[owner_r[s]] <= 1'b0;
            end
          end
          default: state_r[s] <= IDLE;
        endcase
      end
    end
  end

  a_params: assert property (@(posedge clk_i)
    num_slot_p >= 1 && (num_slot_p & (num_slot_p - 1)) == 0 && num_slot_p <= num_cache_p);

  for (genvar s = 0; s < num_slot_p; s++) begin : g_chk
    a_fill_only_in_read: assert property (@(posedge clk_i) disable iff (reset_i)
      bus.slot_dma_data_v_i[s] |-> state_r[s] == READ);
    a_pkt_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
      bus.slot_dma_pkt_yumi_i[s] |-> bus.slot_dma_pkt_v_o[s]);
    a_data_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
      bus.slot_dma_data_yumi_i[s] |-> bus.slot_dma_data_v_o[s]);
  end
endmodule

// File: tb/tb_mc_cache_dma_slot_xbar.sv
// Scoreboard bench for mc_cache_dma_slot_xbar: u0 uses cache-index mapping,
// u1 uses address interleave; both have 4 caches, 2 slots, 32B blocks.
module tb_mc_cache_dma_slot_xbar;
  localparam int nc = 4;
  localparam int ns = 2;
  localparam int aw = 28;
  localparam int dw = 32;
  localparam int bw = 8;
  localparam int pw = aw + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [dw-1:0] exp_q  [$];
  logic [dw-1:0] exp_q1 [$];
  int            grant_q[$];

  always #5 clk = ~clk;

  mc_cache_dma_slot_xbar_if #(.num_cache_p(nc), .num_slot_p(ns),
    .addr_width_p(aw), .data_width_p(dw)) b0 ();
  mc_cache_dma_slot_xbar_if #(.num_cache_p(nc), .num_slot_p(ns),
    .addr_width_p(aw), .data_width_p(dw)) b1 ();

  mc_cache_dma_slot_xbar #(.num_cache_p(nc), .num_slot_p(ns), .addr_width_p(aw),
    .data_width_p(dw), .block_size_in_words_p(bw), .sel_mode_p(0))
    u0 (.clk_i(clk), .reset_i(reset), .bus(b0));
  mc_cache_dma_slot_xbar #(.num_cache_p(nc), .num_slot_p(ns), .addr_width_p(aw),
    .data_width_p(dw), .block_size_in_words_p(bw), .sel_mode_p(1))
    u1 (.clk_i(clk), .reset_i(reset), .bus(b1));

  function automatic logic [pw-1:0] pkt(input logic wr, input logic [aw-1:0] a);
    return {wr, a};
  endfunction

  task automatic clear_inputs();
    b0.dma_pkt_i = '0; b0.dma_pkt_v_i = '0; b0.dma_data_ready_i = '0;
    b0.dma_data_i = '0; b0.dma_data_v_i = '0; b0.slot_dma_pkt_yumi_i = '0;
    b0.slot_dma_data_i = '0; b0.slot_dma_data_v_i = '0; b0.slot_dma_data_yumi_i = '0;
    b1.dma_pkt_i = '0; b1.dma_pkt_v_i = '0; b1.dma_data_ready_i = '0;
    b1.dma_data_i = '0; b1.dma_data_v_i = '0; b1.slot_dma_pkt_yumi_i = '0;
    b1.slot_dma_data_i = '0; b1.slot_dma_data_v_i = '0; b1.slot_dma_data_yumi_i = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    b0.dma_pkt_v_i = '1;
    b0.dma_data_ready_i = '1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (b0.slot_dma_pkt_v_o !== 2'b00) begin
      failures++; $display("FAIL reset_pkt_v got=%b exp=00", b0.slot_dma_pkt_v_o);
    end
    checks++;
    if (b0.dma_pkt_yumi_o !== 4'b0000 || b0.dma_data_v_o !== 4'b0000) begin
      failures++; $display("FAIL reset_cache_outs yumi=%b v=%b exp=0", b0.dma_pkt_yumi_o, b0.dma_data_v_o);
    end
    checks++;
    if (b0.slot_dma_data_ready_o !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", b0.slot_dma_data_ready_o);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
  endtask

  // Cache 2 reads 0x100 on u0 slot 0; optional 3-cycle ready drop after beat 3.
  task automatic test_read(input string name, input int stall_len);
    int sent = 0;
    int stalled = 0;
    logic rdy;
    logic [dw-1:0] e;
    @(negedge clk);
    b0.dma_pkt_i[2] = pkt(1'b0, 28'h100);
    b0.dma_pkt_v_i[2] = 1'b1;
    #1;
    checks++;
    if (b0.slot_dma_pkt_v_o !== 2'b01 || b0.slot_dma_pkt_o[0] !== pkt(1'b0, 28'h100)) begin
      failures++; $display("FAIL %s_pkt v=%b pkt=%h exp v=01 pkt=%h", name,
        b0.slot_dma_pkt_v_o, b0.slot_dma_pkt_o[0], pkt(1'b0, 28'h100));
    end
    b0.slot_dma_pkt_yumi_i[0] = 1'b1;
    #1;
    checks++;
    if (b0.dma_pkt_yumi_o !== 4'b0100) begin
      failures++; $display("FAIL %s_yumi got=%b exp=0100", name, b0.dma_pkt_yumi_o);
    end
    for (int k = 0; k < bw; k++) exp_q.push_back(32'hA0 + k);
    for (int cyc = 0; cyc < 64 && sent < bw; cyc++) begin
      @(negedge clk);
      b0.dma_pkt_v_i[2] = 1'b0;
      b0.slot_dma_pkt_yumi_i[0] = 1'b0;
      rdy = !(sent == 3 && stalled < stall_len);
      if (!rdy) stalled++;
      b0.slot_dma_data_v_i[0] = 1'b1;
      b0.slot_dma_data_i[0] = 32'hA0 + sent;
      b0.dma_data_ready_i[2] = rdy;
      #1;
      checks++;
      if (b0.slot_dma_data_ready_o[0] !== rdy || b0.dma_data_v_o !== 4'b0100) begin
        failures++; $display("FAIL %s_ready beat=%0d ready=%b v=%b exp ready=%b v=0100",
          name, sent, b0.slot_dma_data_ready_o[0], b0.dma_data_v_o, rdy);
      end
      if (rdy) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (b0.dma_data_o[2] !== e) begin
          failures++; $display("FAIL %s_data beat=%0d got=%h exp=%h", name, sent, b0.dma_data_o[2], e);
        end
        sent++;
      end
    end
    @(negedge clk);
    b0.slot_dma_data_v_i[0] = 1'b0;
    #1;
    checks++;
    if (sent != bw || exp_q.size() != 0 || b0.slot_dma_data_ready_o !== 2'b00) begin
      failures++; $display("FAIL %s_end beats=%0d left=%0d ready=%b exp beats=8 left=0 ready=00",
        name, sent, exp_q.size(), b0.slot_dma_data_ready_o);
    end
    clear_inputs();
  endtask

  task automatic test_parallel();
    int sent0 = 0;
    int sent1 = 0;
    int done0 = -1;
    int done1 = -2;
    logic [dw-1:0] e;
    @(negedge clk);
    b0.dma_pkt_i[0] = pkt(1'b0, 28'h200);
    b0.dma_pkt_i[1] = pkt(1'b0, 28'h300);
    b0.dma_pkt_v_i = 4'b0011;
    #1;
    checks++;
    if (b0.slot_dma_pkt_v_o !== 2'b11) begin
      failures++; $display("FAIL par_pkt_v got=%b exp=11", b0.slot_dma_pkt_v_o);
    end
    b0.slot_dma_pkt_yumi_i = 2'b11;
    #1;
    checks++;
    if (b0.dma_pkt_yumi_o !== 4'b0011) begin
      failures++; $display("FAIL par_yumi got=%b exp=0011", b0.dma_pkt_yumi_o);
    end
    for (int k = 0; k < bw; k++) begin
      exp_q.push_back(32'hB0 + k);
      exp_q1.push_back(32'hC0 + k);
    end
    for (int cyc = 0; cyc < 32 && (sent0 < bw || sent1 < bw); cyc++) begin
      @(negedge clk);
      b0.dma_pkt_v_i = '0;
      b0.slot_dma_pkt_yumi_i = '0;
      b0.dma_data_ready_i = 4'b0011;
      b0.slot_dma_data_v_i = {sent1 < bw, sent0 < bw};
      b0.slot_dma_data_i[0] = 32'hB0 + sent0;
      b0.slot_dma_data_i[1] = 32'hC0 + sent1;
      #1;
      if (b0.dma_data_v_o[0]) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (b0.dma_data_o[0] !== e) begin
          failures++; $display("FAIL par_data0 got=%h exp=%h", b0.dma_data_o[0], e);
        end
        sent0++;
        if (sent0 == bw) done0 = cyc;
      end
      if (b0.dma_data_v_o[1]) begin
        e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (b0.dma_data_o[1] !== e) begin
          failures++; $display("FAIL par_data1 got=%h exp=%h", b0.dma_data_o[1], e);
        end
        sent1++;
        if (sent1 == bw) done1 = cyc;
      end
    end
    @(negedge clk);
    b0.slot_dma_data_v_i = '0;
    #1;
    checks++;
    if (done0 != done1 || sent0 != bw || sent1 != bw || b0.slot_dma_data_ready_o !== 2'b00) begin
      failures++; $display("FAIL par_finish done0=%0d done1=%0d beats=%0d/%0d ready=%b exp same cycle 8/8 ready=00",
        done0, done1, sent0, sent1, b0.slot_dma_data_ready_o);
    end
    clear_inputs();
  endtask

  task automatic test_mode1();
    @(negedge clk);
    b1.dma_pkt_i[0] = pkt(1'b0, 28'h00);
    b1.dma_pkt_i[1] = pkt(1'b0, 28'h20);
    b1.dma_pkt_i[2] = pkt(1'b0, 28'h40);
    b1.dma_pkt_v_i = 4'b0011;
    #1;
    checks++;
    if (b1.slot_dma_pkt_v_o !== 2'b11 || b1.slot_dma_pkt_o[0] !== pkt(1'b0, 28'h00)
        || b1.slot_dma_pkt_o[1] !== pkt(1'b0, 28'h20)) begin
      failures++; $display("FAIL mode1_route v=%b s0=%h s1=%h exp v=11 s0=%h s1=%h",
        b1.slot_dma_pkt_v_o, b1.slot_dma_pkt_o[0], b1.slot_dma_pkt_o[1],
        pkt(1'b0, 28'h00), pkt(1'b0, 28'h20));
    end
    @(negedge clk);
    b1.dma_pkt_v_i = 4'b0100;
    #1;
    checks++;
    if (b1.slot_dma_pkt_v_o !== 2'b01 || b1.slot_dma_pkt_o[0] !== pkt(1'b0, 28'h40)) begin
      failures++; $display("FAIL mode1_0x40 v=%b s0=%h exp v=01 s0=%h",
        b1.slot_dma_pkt_v_o, b1.slot_dma_pkt_o[0], pkt(1'b0, 28'h40));
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // All four caches write to slot 0 of u1 together; grants must be 0,1,2,3.
  task automatic test_back_to_back();
    bit pend [nc];
    bit granted [nc];
    int idx [nc];
    int done = 0;
    int last_end = -1;
    int g;
    logic [dw-1:0] e;
    for (int c = 0; c < nc; c++) begin
      pend[c] = 1'b1; granted[c] = 1'b0; idx[c] = 0;
      b1.dma_pkt_i[c] = pkt(1'b1, 28'h0);
      grant_q.push_back(c);
    end
    for (int cyc = 0; cyc < 200 && done < nc; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < nc; c++) begin
        b1.dma_pkt_v_i[c] = pend[c];
        b1.dma_data_v_i[c] = granted[c] && idx[c] < bw;
        b1.dma_data_i[c] = 32'(c * 256 + idx[c]);
      end
      b1.slot_dma_pkt_yumi_i = '0;
      b1.slot_dma_data_yumi_i = '0;
      #1;
      b1.slot_dma_pkt_yumi_i[0] = b1.slot_dma_pkt_v_o[0];
      b1.slot_dma_data_yumi_i[0] = b1.slot_dma_data_v_o[0];
      if (b1.slot_dma_data_v_o[0]) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (b1.slot_dma_data_o[0] !== e) begin
          failures++; $display("FAIL b2b_data got=%h exp=%h", b1.slot_dma_data_o[0], e);
        end
      end
      #1;
      if (b1.slot_dma_pkt_yumi_i[0]) begin
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 0;
        checks++;
        if (b1.dma_pkt_yumi_o !== 4'(1 << g)) begin
          failures++; $display("FAIL b2b_grant got=%b exp=%b", b1.dma_pkt_yumi_o, 4'(1 << g));
        end
        if (last_end >= 0) begin
          checks++;
          if (cyc != last_end + 1) begin
            failures++; $display("FAIL b2b_gap grant_cycle=%0d exp=%0d", cyc, last_end + 1);
          end
        end
        for (int c = 0; c < nc; c++) begin
          if (b1.dma_pkt_yumi_o[c]) begin
            pend[c] = 1'b0; granted[c] = 1'b1;
            for (int k = 0; k < bw; k++) exp_q.push_back(32'(c * 256 + k));
          end
        end
      end
      for (int c = 0; c < nc; c++) begin
        if (b1.dma_data_yumi_o[c]) begin
          idx[c]++;
          if (idx[c] == bw) begin
            granted[c] = 1'b0; done++; last_end = cyc;
          end
        end
      end
    end
    checks++;
    if (done != nc || exp_q.size() != 0 || grant_q.size() != 0) begin
      failures++; $display("FAIL b2b_end done=%0d left=%0d grants_left=%0d exp 4/0/0",
        done, exp_q.size(), grant_q.size());
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    @(negedge clk);
    b1.dma_pkt_i[1] = pkt(1'b1, 28'h0);
    b1.dma_pkt_v_i[1] = 1'b1;
    #1;
    b1.slot_dma_pkt_yumi_i[0] = b1.slot_dma_pkt_v_o[0];
    #1;
    checks++;
    if (b1.dma_pkt_yumi_o !== 4'b0010) begin
      failures++; $display("FAIL rmid_grant got=%b exp=0010", b1.dma_pkt_yumi_o);
    end
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      @(negedge clk);
      b1.dma_pkt_v_i = '0;
      b1.slot_dma_pkt_yumi_i = '0;
      b1.dma_data_v_i[1] = 1'b1;
      b1.dma_data_i[1] = 32'h100 + idx;
      b1.slot_dma_data_yumi_i[0] = 1'b0;
      #1;
      b1.slot_dma_data_yumi_i[0] = b1.slot_dma_data_v_o[0];
      #1;
      if (b1.dma_data_yumi_o[1]) idx++;
    end
    @(negedge clk);
    reset = 1'b1;
    b1.slot_dma_data_yumi_i = '0;
    repeat (2) begin
      #1;
      checks++;
      if (b1.slot_dma_data_v_o !== 2'b00 || b1.dma_data_yumi_o !== 4'b0000
          || b1.slot_dma_pkt_v_o !== 2'b00 || b1.dma_pkt_yumi_o !== 4'b0000) begin
        failures++; $display("FAIL rmid_zero sv=%b dy=%b pv=%b py=%b exp all 0",
          b1.slot_dma_data_v_o, b1.dma_data_yumi_o, b1.slot_dma_pkt_v_o, b1.dma_pkt_yumi_o);
      end
      @(negedge clk);
    end
    clear_inputs();
    reset = 1'b0;
    b1.dma_pkt_i[1] = pkt(1'b0, 28'h0);
    b1.dma_pkt_v_i[1] = 1'b1;
    #1;
    b1.slot_dma_pkt_yumi_i[0] = b1.slot_dma_pkt_v_o[0];
    #1;
    checks++;
    if (b1.dma_pkt_yumi_o !== 4'b0010 || b1.slot_dma_data_v_o !== 2'b00) begin
      failures++; $display("FAIL rmid_new_read yumi=%b sv=%b exp yumi=0010 sv=00",
        b1.dma_pkt_yumi_o, b1.slot_dma_data_v_o);
    end
    @(negedge clk);
    clear_inputs();
    b1.dma_data_ready_i[1] = 1'b1;
    #1;
    checks++;
    if (b1.slot_dma_data_ready_o !== 2'b01) begin
      failures++; $display("FAIL rmid_in_read ready=%b exp=01", b1.slot_dma_data_ready_o);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_read("read", 0);
    test_read("stall", 3);
    test_parallel();
    test_mode1();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
